// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - shared types and default widths for the memory copy engine
//   Contents: W/A default widths, FSM state encoding, copy direction.
package mem_copy_pkg;

  localparam int W = 8;
  localparam int A = 8;

  // Engine FSM state encoding; the engine mirrors these as 2-bit constants.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // ASC walks both pointers upward from the first words, DESC walks downward
  // from the last words so an overlapping destination never clobbers unread source.
  typedef enum logic {
    DIR_ASC  = 1'b0,
    DIR_DESC = 1'b1
  } dir_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - data memory port shared by the copy engine and the memory
//   master: MemWrite, DataAddress, DataIn out; DataOut in (combinational read data)
//   slave : the data memory side of the same signals
interface mem_copy_engine_if #(
  parameter int W = 8,
  parameter int A = 8
) ();

  logic         MemWrite;
  logic [A-1:0] DataAddress;
  logic [W-1:0] DataIn;
  logic [W-1:0] DataOut;

  modport master (
    output MemWrite,
    output DataAddress,
    output DataIn,
    input  DataOut
  );

  modport slave (
    input  MemWrite,
    input  DataAddress,
    input  DataIn,
    output DataOut
  );

endinterface

// File: rtl/copy_dir_calc.sv
// rtl/copy_dir_calc.sv - chooses copy direction and first pointers for a request
//   SrcAddr, DstAddr : first source / destination address
//   Len              : word count, 0..2**A
//   dir              : DIR_DESC when the destination starts inside the source range
//   src_start, dst_start : pointers for the first word moved
module copy_dir_calc
  import mem_copy_pkg::*;
#(
  parameter int A = 8
) (
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A:0]   Len,
  output dir_e         dir,
  output logic [A-1:0] src_start,
  output logic [A-1:0] dst_start
);

  localparam logic [A-1:0] ONE = {{(A-1){1'b0}}, 1'b1};

  logic [A-1:0] delta;
  logic [A-1:0] last_off;
  logic         overlap;

  // Distance from source to destination around the ring. If the destination
  // lands inside [Src, Src+Len) an ascending copy would overwrite unread words.
  assign delta    = DstAddr - SrcAddr;
  // Len = 2**A has zero low bits, so this still yields 2**A-1 as required.
  assign last_off = Len[A-1:0] - ONE;
  assign overlap  = (Len != '0) && (delta != '0) && ({1'b0, delta} < Len);

  assign dir       = overlap ? DIR_DESC : DIR_ASC;
  assign src_start = overlap ? (SrcAddr + last_off) : SrcAddr;
  assign dst_start = overlap ? (DstAddr + last_off) : DstAddr;

endmodule

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - memmove-style word copier driving a single-port data memory
//   Clk, Reset       : clock, synchronous active-high reset
//   Start            : request pulse, accepted only in IDLE
//   SrcAddr, DstAddr : first source / destination address (sampled at acceptance)
//   Len              : word count 0..2**A (sampled at acceptance)
//   Busy, Done       : busy from READ through DONE, one-cycle completion pulse
//   dmem             : memory port (MemWrite, DataAddress, DataIn, DataOut)
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [A-1:0]        SrcAddr,
  input  logic [A-1:0]        DstAddr,
  input  logic [A:0]          Len,
  output logic                Busy,
  output logic                Done,
  mem_copy_engine_if.master   dmem
);

  localparam logic [1:0] IDLE  = S_IDLE;
  localparam logic [1:0] READ  = S_READ;
  localparam logic [1:0] WRITE = S_WRITE;
  localparam logic [1:0] DONE  = S_DONE;

  localparam logic [A-1:0] PTR_ONE = {{(A-1){1'b0}}, 1'b1};
  localparam logic [A:0]   CNT_ONE = {{A{1'b0}}, 1'b1};

  logic [1:0]   state;
  logic [A-1:0] src_ptr;
  logic [A-1:0] dst_ptr;
  logic [A:0]   remaining;
  dir_e         dir;
  logic [W-1:0] data_latch;

  dir_e         calc_dir;
  logic [A-1:0] calc_src;
  logic [A-1:0] calc_dst;

  copy_dir_calc #(.A(A)) u_dir_calc (
    .SrcAddr   (SrcAddr),
    .DstAddr   (DstAddr),
    .Len       (Len),
    .dir       (calc_dir),
    .src_start (calc_src),
    .dst_start (calc_dst)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remaining  <= '0;
      dir        <= DIR_ASC;
      data_latch <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            dir       <= calc_dir;
            src_ptr   <= calc_src;
            dst_ptr   <= calc_dst;
            remaining <= Len;
            state     <= (Len != '0) ? READ : DONE;
          end
        end
        READ: begin
          data_latch <= dmem.DataOut;
          state      <= WRITE;
        end
        WRITE: begin
          if (dir == DIR_DESC) begin
            src_ptr <= src_ptr - PTR_ONE;
            dst_ptr <= dst_ptr - PTR_ONE;
          end else begin
            src_ptr <= src_ptr + PTR_ONE;
            dst_ptr <= dst_ptr + PTR_ONE;
          end
          remaining <= remaining - CNT_ONE;
          state     <= (remaining == CNT_ONE) ? DONE : READ;
        end
        default: begin
          // DONE: Start is deliberately not looked at here.
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dmem.MemWrite    = 1'b0;
    dmem.DataAddress = '0;
    dmem.DataIn      = '0;
    Done             = 1'b0;
    Busy             = (state != IDLE);
    case (state)
      READ: begin
        dmem.DataAddress = src_ptr;
      end
      WRITE: begin
        dmem.DataAddress = dst_ptr;
        dmem.DataIn      = data_latch;
        // Gated with Reset so an aborting reset edge never commits a write.
        dmem.MemWrite    = !Reset;
      end
      DONE: begin
        Done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - scoreboard bench for mem_copy_engine with a behavioural data memory
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  localparam int TW = 8;
  localparam int TA = 8;
  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_DN = 2;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [7:0]  data;
    int          at;
  } item_t;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [TA-1:0] SrcAddr;
  logic [TA-1:0] DstAddr;
  logic [TA:0]   Len;
  logic          Busy;
  logic          Done;

  int    cyc = 0;
  int    n_total = 0;
  int    n_bad = 0;
  item_t exp_q[$];

  mem_copy_engine_if #(.W(TW), .A(TA)) bus ();

  mem_copy_engine #(.W(TW), .A(TA)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .SrcAddr (SrcAddr),
    .DstAddr (DstAddr),
    .Len     (Len),
    .Busy    (Busy),
    .Done    (Done),
    .dmem    (bus)
  );

  // Data memory: combinational read, write on posedge; bench preload port
  // is only used while the engine is idle.
  logic [TW-1:0] mem [0:(2**TA)-1];
  logic          pl_we;
  logic [TA-1:0] pl_addr;
  logic [TW-1:0] pl_data;

  always @(posedge Clk) begin
    if (bus.MemWrite) mem[bus.DataAddress] <= bus.DataIn;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end
  assign bus.DataOut = mem[bus.DataAddress];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: every busy cycle is popped against the next expected bus cycle.
  always @(negedge Clk) begin
    item_t e;
    int    k;
    if (!Reset && (Busy || Done || bus.MemWrite)) begin
      k = Done ? K_DN : (bus.MemWrite ? K_WR : K_RD);
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_cycle: kind=%0d addr=%02h cyc=%0d, required no activity",
                 k, bus.DataAddress, cyc);
      end else begin
        e = exp_q.pop_front();
        if (k != e.kind || cyc != e.at || bus.DataAddress != e.addr ||
            (k == K_WR && bus.DataIn != e.data) || !Busy) begin
          n_bad++;
          $display("FAIL bus_cycle: got kind=%0d addr=%02h data=%02h cyc=%0d busy=%0b, required kind=%0d addr=%02h data=%02h cyc=%0d busy=1",
                   k, bus.DataAddress, bus.DataIn, cyc, Busy, e.kind, e.addr, e.data, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h required %02h", name, act, req);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    @(posedge Clk);
    #1;
    pl_we   = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, 8'(Busy), 8'h00);
    check({name, "_done"}, 8'(Done), 8'h00);
    check({name, "_we"},   8'(bus.MemWrite), 8'h00);
    check({name, "_addr"}, bus.DataAddress, 8'h00);
    check({name, "_din"},  bus.DataIn, 8'h00);
  endtask

  // Push the hand-derived bus trace: n read/write pairs then DONE at 2n.
  task automatic expect_copy(input int t0, input logic [7:0] s0, input logic [7:0] d0,
                             input int step, input int n, input logic [63:0] data);
    logic [7:0] a;
    for (int k = 0; k < n; k++) begin
      a = s0 + 8'(k * step);
      exp_q.push_back('{K_RD, a, 8'h00, t0 + 2 * k});
      a = d0 + 8'(k * step);
      exp_q.push_back('{K_WR, a, data[8*k +: 8], t0 + 2 * k + 1});
    end
    exp_q.push_back('{K_DN, 8'h00, 8'h00, t0 + 2 * n});
  endtask

  task automatic run(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                     input logic [7:0] s0, input logic [7:0] d0, input int step,
                     input logic [63:0] data, input bit hold);
    int t0;
    bit seen;
    SrcAddr = s;
    DstAddr = d;
    Len     = n;
    Start   = 1'b1;
    @(posedge Clk);
    #1;
    t0 = cyc;
    expect_copy(t0, s0, d0, step, int'(n), data);
    if (hold) begin
      // Keep Start high and disturb the request inputs through the whole run.
      SrcAddr = ~s;
      DstAddr = ~d;
      Len     = 9'd3;
    end else begin
      Start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge Clk);
      if (Done) seen = 1'b1;
    end
    check("done_seen", 8'(seen), 8'h01);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    @(negedge Clk);
    check_idle("idle_after");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset   = 1'b1;
    Start   = 1'b0;
    SrcAddr = '0;
    DstAddr = '0;
    Len     = '0;
    pl_we   = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_idle("reset");
    #1;
    Reset = 1'b0;

    // Plain ascending copy, Start held through busy and DONE cycles.
    preload(8'h10, 8'hA1); preload(8'h11, 8'hB2); preload(8'h12, 8'hC3); preload(8'h13, 8'hD4);
    preload(8'h40, 8'h00); preload(8'h41, 8'h00); preload(8'h42, 8'h00); preload(8'h43, 8'h00);
    run(8'h10, 8'h40, 9'd4, 8'h10, 8'h40, 1, 64'hD4C3B2A1, 1'b1);
    check("t1_dst0", mem[8'h40], 8'hA1);
    check("t1_dst3", mem[8'h43], 8'hD4);
    check("t1_src0", mem[8'h10], 8'hA1);
    check("t1_src3", mem[8'h13], 8'hD4);

    // Forward overlap: must run descending.
    preload(8'h20, 8'h01); preload(8'h21, 8'h02); preload(8'h22, 8'h03); preload(8'h23, 8'h04);
    run(8'h20, 8'h22, 9'd4, 8'h23, 8'h25, -1, 64'h01020304, 1'b0);
    check("t2_m20", mem[8'h20], 8'h01);
    check("t2_m21", mem[8'h21], 8'h02);
    check("t2_m22", mem[8'h22], 8'h01);
    check("t2_m23", mem[8'h23], 8'h02);
    check("t2_m24", mem[8'h24], 8'h03);
    check("t2_m25", mem[8'h25], 8'h04);

    // Backward overlap: ascending is safe.
    preload(8'h22, 8'h05); preload(8'h23, 8'h06); preload(8'h24, 8'h07); preload(8'h25, 8'h08);
    run(8'h22, 8'h20, 9'd4, 8'h22, 8'h20, 1, 64'h08070605, 1'b0);
    check("t3_m20", mem[8'h20], 8'h05);
    check("t3_m21", mem[8'h21], 8'h06);
    check("t3_m22", mem[8'h22], 8'h07);
    check("t3_m23", mem[8'h23], 8'h08);

    // Source range wrapping past 0xFF.
    preload(8'hFE, 8'h09); preload(8'hFF, 8'h0A); preload(8'h00, 8'h0B);
    run(8'hFE, 8'h80, 9'd3, 8'hFE, 8'h80, 1, 64'h000B0A09, 1'b0);
    check("t4_m80", mem[8'h80], 8'h09);
    check("t4_m81", mem[8'h81], 8'h0A);
    check("t4_m82", mem[8'h82], 8'h0B);

    // Zero length with Start held into the DONE cycle.
    run(8'h30, 8'h50, 9'd0, 8'h30, 8'h50, 1, 64'h0, 1'b1);

    // Reset during the second WRITE of an 8-word copy.
    for (int i = 0; i < 8; i++) preload(8'h60 + 8'(i), 8'h11 * 8'(i + 1));
    preload(8'h70, 8'hEE); preload(8'h71, 8'hEE);
    SrcAddr = 8'h60;
    DstAddr = 8'h70;
    Len     = 9'd8;
    Start   = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    exp_q.push_back('{K_RD, 8'h60, 8'h00, cyc});
    exp_q.push_back('{K_WR, 8'h70, 8'h11, cyc + 1});
    exp_q.push_back('{K_RD, 8'h61, 8'h00, cyc + 2});
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_we_gated", 8'(bus.MemWrite), 8'h00);
    check("rst_addr", bus.DataAddress, 8'h71);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    check_idle("post_reset");
    check("rst_m70", mem[8'h70], 8'h11);
    check("rst_m71", mem[8'h71], 8'hEE);
    check("rst_queue", 8'(exp_q.size()), 8'h00);
    run(8'h60, 8'h90, 9'd2, 8'h60, 8'h90, 1, 64'h2211, 1'b0);
    check("t6_m90", mem[8'h90], 8'h11);
    check("t6_m91", mem[8'h91], 8'h22);

    repeat (3) @(negedge Clk);
    check("final_queue", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
